serial_adder_driver: RTL and testbench
======================================

// Module: serial_adder_driver
// PURPOSE
//  Feeds a serial_adder_with_vld: accepts one pair of parallel WIDTH-bit operands per
//  transaction via a valid/ready handshake, shifts them out LSB-first as a/b/vld/last, and
//  collects the returned serial sum bits into a parallel WIDTH-bit result.
//  Sits between the parallel request source and the bit-serial adder datapath.
// PARAMETERS
//  WIDTH  4  operand/result width in bits; legal range >= 1
// PORTS
//  clk      in   1      single clock, all logic on posedge
//  rst      in   1      synchronous, active-high reset
//  up_vld   in   1      operand pair valid
//  up_rdy   out  1      driver can accept an operand pair this cycle
//  up_a     in   WIDTH  operand A
//  up_b     in   WIDTH  operand B
//  hold     in   1      insert bubble: suppress ser_vld this cycle
//  ser_vld  out  1      to adder vld
//  ser_a    out  1      to adder a (current bit of A)
//  ser_b    out  1      to adder b (current bit of B)
//  ser_last out  1      to adder last (MSB beat)
//  ser_sum  in   1      from adder sum; combinational, valid in the same cycle as ser_vld
//  res_vld  out  1      one-cycle pulse: res_sum updated
//  res_sum  out  WIDTH  assembled sum, modulo 2^WIDTH; holds until next result
// BEHAVIOUR
//  - Reset values: state=IDLE, bit counter=0, shift regs=0, up_rdy=1 (after reset),
//    ser_vld=0, ser_last=0, ser_a=0, ser_b=0, res_vld=0, res_sum=0.
//  - FSM, two states:
//    IDLE: up_rdy=1. up_vld&up_rdy loads A/B shift regs, clears cnt, -> SEND.
//    SEND: ser_vld = !hold. On each beat (ser_vld=1): sample ser_sum into res shift reg
//      at bit cnt, shift A/B right, cnt++. ser_last = ser_vld & (cnt==WIDTH-1).
//      Last beat -> IDLE, unless a new pair is accepted that cycle (see below).
//  - ser_a/ser_b = LSB of the shift regs; held stable during hold bubbles.
//    ser_last is forced 0 whenever ser_vld=0.
//  - hold is ignored in IDLE. During SEND, hold freezes cnt and shift regs (no beat).
//  - Back-to-back: up_rdy also =1 in SEND on the last beat (ser_last=1). An accept on
//    that cycle reloads shift regs, clears cnt, stays in SEND -> zero-gap streaming.
//  - Latency without hold: accept at cycle T, beats at T+1..T+WIDTH, res_vld=1 at T+WIDTH+1
//    with res_sum complete. Each hold cycle adds one cycle.
//  - res_sum is committed from the internal accumulator only on the final beat (registered);
//    partial results are never visible on res_sum.
//  - WIDTH=1: first beat is also last; ser_last=1 on it.
//  - Overflow: carry-out is dropped (the adder clears carry on last); res_sum wraps mod 2^WIDTH.
//  - Reset mid-transaction: transfer abandoned, outputs return to reset values next cycle,
//    no res_vld. The adder shares rst, so its carry is cleared as well.
//  - up_a/up_b are sampled only on accept; later changes have no effect.
// STRUCTURE
//  - serial_adder_pkg: typedef enum logic {IDLE, SEND} sad_state_t; function
//    cnt_w(WIDTH) = $clog2(WIDTH) (min 1).
//  - One sub-module: serial_deserializer (WIDTH; in: clk, rst, bit_vld, bit_in, bit_last;
//    out: word_vld, word). Owns the res shift/accumulator and res_vld/res_sum regs.
//  - The top holds the FSM, cnt, A/B shift regs and the handshake. Bench instantiates
//    serial_adder_with_vld as the DUT partner.
// TESTING (WIDTH=4 unless noted, driver + serial_adder_with_vld in loop)
//  1. A=4'd5, B=4'd3, hold=0 -> beats a=1,0,1,0 / b=1,1,0,0, ser_last on 4th;
//     res_vld at T+5, res_sum=4'd8.
//  2. A=4'd15, B=4'd1 -> res_sum=4'd0 (wrap); next pair A=2,B=2 -> 4 (carry not leaked).
//  3. Stream (1,2),(7,7),(9,6) with up_vld held high -> up_rdy on each last beat,
//     ser_vld continuous for 12 cycles; results 3, 14, 15 at 4-cycle spacing.
//  4. A=6, B=5, hold high for 2 cycles after beat 2 -> ser_vld=0, ser_last=0, ser_a/b
//     stable during bubbles; res_sum=11 at T+7.
//  5. rst=1 after beat 2 of A=9,B=9 -> no res_vld, up_rdy=1; then A=1,B=1 -> res_sum=2.
//  6. WIDTH=1: A=1,B=1 -> ser_vld and ser_last both high in the single beat, res_sum=0;
//     A=1,B=0 -> 1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared types and helpers for the serial adder driver slice.
//             - sad_state_t : two-state driver FSM encoding
//             - cnt_w()     : beat-counter width for a given operand width
//  Revision : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sad_state_t;

    // Width of a counter that indexes bits 0..width-1.
    // At least 1 bit, so WIDTH=1 still has a legal counter.
    function automatic int cnt_w(input int width);
        if (width <= 1) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_with_vld.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_with_vld
//  Purpose  : Bit-serial adder, LSB first, with a beat qualifier.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             vld             - a/b carry a valid bit this cycle
//             a, b            - operand bits
//             last            - MSB beat; carry is cleared after it
//             sum             - combinational sum bit for the current beat
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder_with_vld (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic a,
    input  logic b,
    input  logic last,
    output logic sum
);

    logic r_carry;

    assign sum = a ^ b ^ r_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
        end else if (vld) begin
            // Carry-out of the MSB is dropped so the next word starts clean.
            r_carry <= last ? 1'b0 : ((a & b) | (a & r_carry) | (b & r_carry));
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_deserializer
//  Purpose  : Collects LSB-first serial bits into a WIDTH-bit word and
//             publishes it with a one-cycle valid pulse after the last bit.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             bit_vld         - bit_in is a valid beat
//             bit_in          - serial data bit
//             bit_last        - this beat is the MSB
//             word_vld        - one-cycle pulse, word updated
//             word            - assembled word, held until the next one
//  Revision : 1.0  initial release
// ============================================================================
module serial_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_vld,
    input  logic             bit_in,
    input  logic             bit_last,
    output logic             word_vld,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_word;
    logic             r_word_vld;
    logic [WIDTH-1:0] w_next;

    // Bits enter at the MSB and walk down; after WIDTH beats the first
    // (LSB) bit has reached position 0.
    assign w_next = (r_acc >> 1) | (WIDTH'(bit_in) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_word     <= '0;
            r_word_vld <= 1'b0;
        end else begin
            r_word_vld <= bit_vld & bit_last;
            if (bit_vld) begin
                if (bit_last) begin
                    // Commit only the complete word; partials stay internal.
                    r_word <= w_next;
                    r_acc  <= '0;
                end else begin
                    r_acc  <= w_next;
                end
            end
        end
    end

    assign word_vld = r_word_vld;
    assign word     = r_word;

endmodule
`default_nettype wire

// File: rtl/serial_adder_driver.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_driver
//  Purpose  : Accepts parallel operand pairs over valid/ready, shifts them
//             LSB-first to a bit-serial adder and reassembles the sum.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             up_vld/up_rdy   - operand handshake
//             up_a, up_b      - WIDTH-bit operands (sampled on accept)
//             hold            - bubble request, suppresses a beat in SEND
//             ser_vld/a/b/last- serial stream to the adder
//             ser_sum         - combinational sum bit from the adder
//             res_vld         - one-cycle pulse, res_sum updated
//             res_sum         - WIDTH-bit sum modulo 2^WIDTH
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder_driver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld,
    output logic             up_rdy,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic             hold,
    output logic             ser_vld,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_last,
    input  logic             ser_sum,
    output logic             res_vld,
    output logic [WIDTH-1:0] res_sum
);

    import serial_adder_pkg::*;

    localparam int               CNT_W      = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    sad_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;

    logic w_beat;
    logic w_last;
    logic w_accept;

    assign w_beat   = (r_state == SEND) & ~hold;
    assign w_last   = w_beat & (r_cnt == c_last_cnt);
    // Ready on the final beat as well, so a new pair can follow with no gap.
    assign w_accept = up_vld & up_rdy;

    assign up_rdy   = (r_state == IDLE) | w_last;
    assign ser_vld  = w_beat;
    assign ser_last = w_last;
    // Shift regs only move on a beat, so these stay stable through bubbles.
    assign ser_a    = r_sh_a[0];
    assign ser_b    = r_sh_b[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sh_a  <= up_a;
                        r_sh_b  <= up_b;
                        r_cnt   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_beat) begin
                        if (w_last) begin
                            r_cnt <= '0;
                            if (w_accept) begin
                                r_sh_a  <= up_a;
                                r_sh_b  <= up_b;
                                r_state <= SEND;
                            end else begin
                                r_sh_a  <= r_sh_a >> 1;
                                r_sh_b  <= r_sh_b >> 1;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_sh_a <= r_sh_a >> 1;
                            r_sh_b <= r_sh_b >> 1;
                            r_cnt  <= r_cnt + c_cnt_one;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    serial_deserializer #(
        .WIDTH (WIDTH)
    ) u_deser (
        .clk      (clk),
        .rst      (rst),
        .bit_vld  (w_beat),
        .bit_in   (ser_sum),
        .bit_last (w_last),
        .word_vld (res_vld),
        .word     (res_sum)
    );

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder_driver
//  Purpose  : Self-checking bench: driver + serial adder in loop, WIDTH=4
//             and WIDTH=1 instances, directed cases plus random traffic
//             against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_vld, up_rdy, hold;
    logic [3:0] up_a, up_b;
    logic       ser_vld, ser_a, ser_b, ser_last, ser_sum;
    logic       res_vld;
    logic [3:0] res_sum;

    logic       u1_vld, u1_rdy, u1_a, u1_b;
    logic       s1_vld, s1_a, s1_b, s1_last, s1_sum;
    logic       r1_vld, r1_sum;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_driver #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .up_vld(up_vld), .up_rdy(up_rdy),
        .up_a(up_a), .up_b(up_b), .hold(hold),
        .ser_vld(ser_vld), .ser_a(ser_a), .ser_b(ser_b), .ser_last(ser_last),
        .ser_sum(ser_sum), .res_vld(res_vld), .res_sum(res_sum)
    );
    serial_adder_with_vld u_add (
        .clk(clk), .rst(rst), .vld(ser_vld), .a(ser_a), .b(ser_b),
        .last(ser_last), .sum(ser_sum)
    );

    serial_adder_driver #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .up_vld(u1_vld), .up_rdy(u1_rdy),
        .up_a(u1_a), .up_b(u1_b), .hold(1'b0),
        .ser_vld(s1_vld), .ser_a(s1_a), .ser_b(s1_b), .ser_last(s1_last),
        .ser_sum(s1_sum), .res_vld(r1_vld), .res_sum(r1_sum)
    );
    serial_adder_with_vld u_add1 (
        .clk(clk), .rst(rst), .vld(s1_vld), .a(s1_a), .b(s1_b),
        .last(s1_last), .sum(s1_sum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [7:0] op_q[$];     // accepted {a,b} not yet fully sent
    logic [3:0] exp_q[$];    // sums whose last beat has gone out
    logic [3:0] log_sum[$];
    int         log_cyc[$];
    int         beat = 0;
    logic       pend = 1'b0;

    always @(negedge clk) begin
        logic [7:0] cur;
        if (rst) begin
            op_q.delete();
            exp_q.delete();
            beat = 0;
            pend = 1'b0;
        end else begin
            chk("res_vld", res_vld, pend);
            if (res_vld && pend && exp_q.size() > 0) begin
                chk("res_sum", res_sum, exp_q.pop_front());
                log_sum.push_back(res_sum);
                log_cyc.push_back(cyc);
            end
            pend = 1'b0;
            if (op_q.size() > 0) begin
                cur = op_q[0];
                chk("ser_vld", ser_vld, !hold);
                chk("ser_a", ser_a, cur[4 + beat]);
                chk("ser_b", ser_b, cur[beat]);
                chk("ser_last", ser_last, !hold && beat == 3);
                chk("up_rdy_send", up_rdy, !hold && beat == 3);
                if (!hold) begin
                    if (beat == 3) begin
                        exp_q.push_back(4'((int'(cur[7:4]) + int'(cur[3:0])) % 16));
                        pend = 1'b1;
                        void'(op_q.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
            end else begin
                chk("idle_ser_vld", ser_vld, 1'b0);
                chk("idle_ser_last", ser_last, 1'b0);
                chk("idle_up_rdy", up_rdy, 1'b1);
            end
            if (up_vld && up_rdy) op_q.push_back({up_a, up_b});
        end
    end

    // One transaction; hold asserted for hold_len cycles starting at
    // post-accept cycle hold_from. lat = cycles from accept to res_vld.
    task automatic txn(input logic [3:0] a, input logic [3:0] b,
                       input int hold_from, input int hold_len,
                       output int lat, output logic [3:0] sum);
        int g = 0;
        up_vld = 1'b1; up_a = a; up_b = b;
        while (!up_rdy && g < 20) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        up_vld = 1'b0; up_a = 4'($urandom); up_b = 4'($urandom);
        lat = 99; sum = 4'hx;
        for (int n = 1; n < 20; n++) begin
            hold = (n >= hold_from) && (n < hold_from + hold_len);
            if (res_vld) begin lat = n; sum = res_sum; break; end
            @(posedge clk); #1;
        end
        hold = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int         lat, idx, k, vcount, g, base, nres;
        logic       started, acc;
        logic [3:0] sum;
        logic [3:0] sa[3] = '{4'd1, 4'd7, 4'd9};
        logic [3:0] sb[3] = '{4'd2, 4'd7, 4'd6};

        rst = 1'b1; up_vld = 1'b0; up_a = '0; up_b = '0; hold = 1'b0;
        u1_vld = 1'b0; u1_a = 1'b0; u1_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_up_rdy", up_rdy, 1'b1);
        chk("rst_ser_vld", ser_vld, 1'b0);
        chk("rst_ser_ab", {ser_a, ser_b, ser_last}, 3'b000);
        chk("rst_res", {res_vld, res_sum}, 5'd0);

        // 1: basic add with latency
        txn(4'd5, 4'd3, 99, 0, lat, sum);
        chk("t1_lat", lat, 5);
        chk("t1_sum", sum, 4'd8);

        // 2: wrap then clean carry
        txn(4'd15, 4'd1, 99, 0, lat, sum);
        chk("t2_wrap", sum, 4'd0);
        txn(4'd2, 4'd2, 99, 0, lat, sum);
        chk("t2_next", sum, 4'd4);

        // 4: two-cycle bubble after beat 2
        txn(4'd6, 4'd5, 3, 2, lat, sum);
        chk("t4_lat", lat, 7);
        chk("t4_sum", sum, 4'd11);

        // 3: back-to-back stream
        base = log_sum.size();
        idx = 0; k = 0; vcount = 0; started = 1'b0; g = 0;
        while ((idx < 3 || k < 12) && g < 40) begin
            if (idx < 3) begin up_vld = 1'b1; up_a = sa[idx]; up_b = sb[idx]; end
            else up_vld = 1'b0;
            if (started && k < 12) begin if (ser_vld) vcount++; k++; end
            acc = up_vld && up_rdy;
            @(posedge clk); #1;
            if (acc) begin idx++; started = 1'b1; end
            g++;
        end
        up_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_vld_run", vcount, 12);
        nres = log_sum.size() - base;
        chk("t3_nres", nres, 3);
        if (nres == 3) begin
            chk("t3_r0", log_sum[base], 4'd3);
            chk("t3_r1", log_sum[base + 1], 4'd14);
            chk("t3_r2", log_sum[base + 2], 4'd15);
            chk("t3_gap1", log_cyc[base + 1] - log_cyc[base], 4);
            chk("t3_gap2", log_cyc[base + 2] - log_cyc[base + 1], 4);
        end

        // 5: reset mid-transaction
        base = log_sum.size();
        up_vld = 1'b1; up_a = 4'd9; up_b = 4'd9;
        @(posedge clk); #1;
        up_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("t5_up_rdy", up_rdy, 1'b1);
        chk("t5_out", {ser_vld, ser_last, ser_a, ser_b, res_vld}, 5'd0);
        vcount = 0;
        for (int n = 0; n < 6; n++) begin
            if (res_vld) vcount++;
            @(posedge clk); #1;
        end
        chk("t5_no_res", vcount, 0);
        txn(4'd1, 4'd1, 99, 0, lat, sum);
        chk("t5_sum", sum, 4'd2);

        // 6: WIDTH=1 instance
        u1_vld = 1'b1; u1_a = 1'b1; u1_b = 1'b1;
        chk("w1_rdy", u1_rdy, 1'b1);
        @(posedge clk); #1 u1_vld = 1'b0;
        chk("w1_beat", {s1_vld, s1_last}, 2'b11);
        @(posedge clk); #1;
        chk("w1_res11", {r1_vld, r1_sum}, 2'b10);
        u1_vld = 1'b1; u1_a = 1'b1; u1_b = 1'b0;
        @(posedge clk); #1 u1_vld = 1'b0;
        chk("w1_beat2", {s1_vld, s1_last}, 2'b11);
        @(posedge clk); #1;
        chk("w1_res10", {r1_vld, r1_sum}, 2'b11);

        // random traffic with bubbles
        for (int n = 0; n < 400; n++) begin
            up_vld = 1'($urandom);
            up_a   = 4'($urandom);
            up_b   = 4'($urandom);
            hold   = ($urandom % 4) == 0;
            @(posedge clk); #1;
        end
        up_vld = 1'b0; hold = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_ops", op_q.size(), 0);
        chk("drain_res", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
